// File: rtl/mem_dma_pkg.sv
// State encodings and word/address width defaults for the mem_dma copy engine,
// shared with the memory model that sits on the same data-memory port.
package mem_dma_pkg;

    localparam int WORD_LEN_DEF = 16;
    localparam int ADDR_LEN_DEF = 16;
    localparam int LEN_LEN_DEF  = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The engine owns the memory port only while it is reading or writing.
    function automatic logic is_busy_state(input logic [1:0] st);
        return (st == S_READ) || (st == S_WRITE);
    endfunction

endpackage

// File: rtl/mem_dma_addr_gen.sv
// Pointer/count generator for mem_dma: source and destination pointers that wrap
// modulo 2^p_ADDR_LEN, the words_done counter and the terminal-count flag.
module mem_dma_addr_gen #(
    parameter int p_ADDR_LEN = 16,
    parameter int p_LEN_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [p_ADDR_LEN-1:0] src_in,
    input  logic [p_ADDR_LEN-1:0] dst_in,
    input  logic [p_LEN_LEN-1:0]  len_in,
    output logic [p_ADDR_LEN-1:0] src,
    output logic [p_ADDR_LEN-1:0] dst,
    output logic [p_LEN_LEN-1:0]  words_done,
    output logic                  last
);

    logic [p_ADDR_LEN-1:0] src_q, src_d;
    logic [p_ADDR_LEN-1:0] dst_q, dst_d;
    logic [p_LEN_LEN-1:0]  len_q, len_d;
    logic [p_LEN_LEN-1:0]  cnt_q, cnt_d;

    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        cnt_d = cnt_q;
        if (load) begin
            src_d = src_in;
            dst_d = dst_in;
            len_d = len_in;
            cnt_d = '0;
        end else if (step) begin
            // Truncating add gives the all-ones -> zero wrap directly.
            src_d = src_q + p_ADDR_LEN'(1);
            dst_d = dst_q + p_ADDR_LEN'(1);
            cnt_d = cnt_q + p_LEN_LEN'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is sampled only at posedge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    assign src        = src_q;
    assign dst        = dst_q;
    assign words_done = cnt_q;
    assign last       = (cnt_q + p_LEN_LEN'(1)) == len_q;

endmodule

// File: rtl/mem_dma.sv
// Bus-master block copy engine on the data-memory port (READ/WRITE, 2 cycles/word).
// Optional MEM_DMA_FILL_EN adds a fill mode that writes a constant at 1 cycle/word.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int p_WORD_LEN = WORD_LEN_DEF,
    parameter int p_ADDR_LEN = ADDR_LEN_DEF,
    parameter int p_LEN_LEN  = LEN_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [p_ADDR_LEN-1:0] src_addr,
    input  logic [p_ADDR_LEN-1:0] dst_addr,
    input  logic [p_LEN_LEN-1:0]  length,
`ifdef MEM_DMA_FILL_EN
    input  logic                  fill_mode,
    input  logic [p_WORD_LEN-1:0] fill_value,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [p_LEN_LEN-1:0]  words_done,
    output logic [p_ADDR_LEN-1:0] mem_address,
    output logic [p_WORD_LEN-1:0] mem_dataIn,
    output logic                  mem_writeEn,
    input  logic [p_WORD_LEN-1:0] mem_dataOut
);

    logic [1:0]            state_q, state_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic                  load;
    logic                  step;
    logic                  last;
    logic [p_ADDR_LEN-1:0] src;
    logic [p_ADDR_LEN-1:0] dst;
    logic [1:0]            after_write;

`ifdef MEM_DMA_FILL_EN
    logic fill_mode_q, fill_mode_d;
`endif

    mem_dma_addr_gen #(
        .p_ADDR_LEN (p_ADDR_LEN),
        .p_LEN_LEN  (p_LEN_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .src_in     (src_addr),
        .dst_in     (dst_addr),
        .len_in     (length),
        .src        (src),
        .dst        (dst),
        .words_done (words_done),
        .last       (last)
    );

    // Fill mode loops WRITE->WRITE; copy mode goes back to READ for the next word.
`ifdef MEM_DMA_FILL_EN
    assign after_write = fill_mode_q ? S_WRITE : S_READ;
`else
    assign after_write = S_READ;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = 1'b0;
        step    = 1'b0;
`ifdef MEM_DMA_FILL_EN
        fill_mode_d = fill_mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
`ifdef MEM_DMA_FILL_EN
                    fill_mode_d = fill_mode;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (fill_mode) begin
                        data_d  = fill_value;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
`else
                    state_d = (length == '0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: begin
                data_d  = mem_dataOut;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                step    = 1'b1;
                state_d = last ? S_DONE : after_write;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
`ifdef MEM_DMA_FILL_EN
            fill_mode_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
`ifdef MEM_DMA_FILL_EN
            fill_mode_q <= fill_mode_d;
`endif
        end
    end

    // Port drive is decoded from registered state only; idle port rests at zero.
    always_comb begin
        mem_address = '0;
        mem_dataIn  = '0;
        mem_writeEn = 1'b0;
        case (state_q)
            S_READ: begin
                mem_address = src;
            end
            S_WRITE: begin
                mem_address = dst;
                mem_dataIn  = data_q;
                mem_writeEn = 1'b1;
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

    assign busy = is_busy_state(state_q);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: word-array memory model on the port and a
// forward-copy reference model; MEM_DMA_FILL_EN adds the fill scenario.
module tb_mem_dma;

    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
`ifdef MEM_DMA_FILL_EN
    logic        fill_mode;
    logic [15:0] fill_value;
`endif
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [15:0] mem_address;
    logic [15:0] mem_dataIn;
    logic        mem_writeEn;
    logic [15:0] mem_dataOut;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] mem     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic        init_req = 1'b0;
    logic        pre_we   = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    typedef struct {
        int          lat;
        int          busy_n;
        int          we_n;
        logic [15:0] wd;
        logic        done_after;
        logic        busy_after;
    } obs_t;

    mem_dma dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .length      (length),
`ifdef MEM_DMA_FILL_EN
        .fill_mode   (fill_mode),
        .fill_value  (fill_value),
`endif
        .busy        (busy),
        .done        (done),
        .words_done  (words_done),
        .mem_address (mem_address),
        .mem_dataIn  (mem_dataIn),
        .mem_writeEn (mem_writeEn),
        .mem_dataOut (mem_dataOut)
    );

    // Memory: asynchronous read, out-of-range reads return 0, writes commit on negedge.
    assign mem_dataOut = (mem_address < 16'(DEPTH)) ? mem[mem_address[11:0]] : 16'h0000;

    always @(negedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_writeEn && (mem_address < 16'(DEPTH))) begin
            mem[mem_address[11:0]] <= mem_dataIn;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        #1;
        pre_we = 1'b0;
        ref_mem[a] = v;
        tick();
    endtask

    // Reference: strictly forward word-by-word copy with 16-bit wrap.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [15:0] sa;
        logic [15:0] da;
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
            v  = (sa < 16'(DEPTH)) ? ref_mem[sa[11:0]] : 16'h0000;
            if (da < 16'(DEPTH)) ref_mem[da[11:0]] = v;
        end
    endtask

    function automatic int mem_diff(output int first);
        int bad;
        bad   = 0;
        first = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        return bad;
    endfunction

    // Issue one start and watch until the done pulse (or the budget runs out).
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                            input int budget, output obs_t o);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        o.lat    = -1;
        o.busy_n = 0;
        o.we_n   = 0;
        for (int c = 1; c <= budget; c++) begin
            if (busy === 1'b1) o.busy_n++;
            if (mem_writeEn === 1'b1) o.we_n++;
            if (done === 1'b1) begin
                o.lat = c;
                break;
            end
            tick();
        end
        o.wd = words_done;
        tick();
        o.done_after = done;
        o.busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (words_done !== 16'h0) $display("FAIL reset_words_done got %h want 0000", words_done); else pass_cnt++;
        total_cnt++; if (mem_writeEn !== 1'b0) $display("FAIL reset_writeEn got %b want 0", mem_writeEn); else pass_cnt++;
        total_cnt++; if (mem_address !== 16'h0) $display("FAIL reset_address got %h want 0000", mem_address); else pass_cnt++;
        total_cnt++; if (mem_dataIn !== 16'h0) $display("FAIL reset_dataIn got %h want 0000", mem_dataIn); else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_directed_copy();
        logic [15:0] vals [4];
        obs_t        o;
        int          first;
        int          bad;
        for (int i = 0; i < 4; i++) begin
            vals[i] = 16'($urandom);
            poke(12'h010 + 12'(i), vals[i]);
        end
        model_copy(16'h0010, 16'h0040, 4);
        run_xfer(16'h0010, 16'h0040, 16'd4, 20, o);
        total_cnt++; if (o.lat !== 9) $display("FAIL copy4_latency got %0d want 9", o.lat); else pass_cnt++;
        total_cnt++; if (o.busy_n !== 8) $display("FAIL copy4_busy_cycles got %0d want 8", o.busy_n); else pass_cnt++;
        total_cnt++; if (o.we_n !== 4) $display("FAIL copy4_write_cycles got %0d want 4", o.we_n); else pass_cnt++;
        total_cnt++; if (o.wd !== 16'd4) $display("FAIL copy4_words_done got %0d want 4", o.wd); else pass_cnt++;
        total_cnt++; if (o.done_after !== 1'b0 || o.busy_after !== 1'b0)
            $display("FAIL copy4_after_done got done=%b busy=%b want 0 0", o.done_after, o.busy_after); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (mem[12'h040 + 12'(i)] !== vals[i])
                $display("FAIL copy4_word%0d got %h want %h", i, mem[12'h040 + 12'(i)], vals[i]);
            else pass_cnt++;
        end
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL copy4_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_zero_length();
        obs_t o;
        int   first;
        int   bad;
        run_xfer(16'h0123, 16'h0456, 16'd0, 6, o);
        total_cnt++; if (o.lat !== 1) $display("FAIL len0_latency got %0d want 1", o.lat); else pass_cnt++;
        total_cnt++; if (o.we_n !== 0) $display("FAIL len0_write_cycles got %0d want 0", o.we_n); else pass_cnt++;
        total_cnt++; if (o.busy_n !== 0) $display("FAIL len0_busy_cycles got %0d want 0", o.busy_n); else pass_cnt++;
        total_cnt++; if (o.wd !== 16'd0) $display("FAIL len0_words_done got %0d want 0", o.wd); else pass_cnt++;
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL len0_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [15:0] v0;
        obs_t        o;
        int          first;
        int          bad;
        v0 = 16'($urandom) | 16'h0001;
        poke(12'h000, v0);
        model_copy(16'hFFFF, 16'h0020, 2);
        run_xfer(16'hFFFF, 16'h0020, 16'd2, 12, o);
        total_cnt++; if (o.lat !== 5) $display("FAIL wrap_latency got %0d want 5", o.lat); else pass_cnt++;
        total_cnt++; if (mem[12'h020] !== 16'h0000) $display("FAIL wrap_word0 got %h want 0000", mem[12'h020]); else pass_cnt++;
        total_cnt++; if (mem[12'h021] !== v0) $display("FAIL wrap_word1 got %h want %h", mem[12'h021], v0); else pass_cnt++;
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL wrap_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_random_copies();
        obs_t        o;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] n;
        int          first;
        int          bad;
        for (int t = 0; t < 25; t++) begin
            s = ($urandom_range(0, 7) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom_range(0, DEPTH - 1));
            d = ($urandom_range(0, 7) == 0) ? 16'h0FF8 + 16'($urandom_range(0, 7))
                                            : (($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(1, 4))
                                                                           : 16'($urandom_range(0, DEPTH - 1)));
            n = 16'($urandom_range(0, 12));
            model_copy(s, d, int'(n));
            run_xfer(s, d, n, 2 * int'(n) + 6, o);
            total_cnt++; if (o.lat !== 2 * int'(n) + 1) $display("FAIL rand%0d_latency got %0d want %0d", t, o.lat, 2 * int'(n) + 1); else pass_cnt++;
            total_cnt++; if (o.busy_n !== 2 * int'(n)) $display("FAIL rand%0d_busy_cycles got %0d want %0d", t, o.busy_n, 2 * int'(n)); else pass_cnt++;
            total_cnt++; if (o.we_n !== int'(n)) $display("FAIL rand%0d_write_cycles got %0d want %0d", t, o.we_n, n); else pass_cnt++;
            total_cnt++; if (o.wd !== n) $display("FAIL rand%0d_words_done got %0d want %0d", t, o.wd, n); else pass_cnt++;
            bad = mem_diff(first);
            total_cnt++; if (bad !== 0) $display("FAIL rand%0d_memory src=%h dst=%h len=%0d got %0d bad words (first 0x%0h) want 0",
                                                 t, s, d, n, bad, first); else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        int first_done;
        int first;
        int bad;
        model_copy(16'h0200, 16'h0300, 3);
        src_addr = 16'h0200;
        dst_addr = 16'h0300;
        length   = 16'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        src_addr = 16'h0280;
        dst_addr = 16'h0380;
        length   = 16'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        pulses     = 0;
        first_done = -1;
        for (int c = 3; c <= 30; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = c;
            end
            tick();
        end
        total_cnt++; if (pulses !== 1) $display("FAIL busy_start_pulses got %0d want 1", pulses); else pass_cnt++;
        total_cnt++; if (first_done !== 7) $display("FAIL busy_start_latency got %0d want 7", first_done); else pass_cnt++;
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL busy_start_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int got;
        int we_seen;
        int first;
        int bad;
        model_copy(16'h0500, 16'h0600, 2);
        src_addr = 16'h0500;
        dst_addr = 16'h0600;
        length   = 16'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        got      = 0;
        for (int c = 0; c < 20; c++) begin
            if (words_done === 16'd2) begin
                got = 1;
                break;
            end
            tick();
        end
        total_cnt++; if (got !== 1) $display("FAIL abort_reach_two got %0d want 1 (timeout)", got); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (mem_writeEn !== 1'b0) $display("FAIL abort_writeEn got %b want 0", mem_writeEn); else pass_cnt++;
        total_cnt++; if (words_done !== 16'd0) $display("FAIL abort_words_done got %0d want 0", words_done); else pass_cnt++;
        rst     = 1'b1;
        we_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_writeEn === 1'b1 || done === 1'b1) we_seen++;
            tick();
        end
        total_cnt++; if (we_seen !== 0) $display("FAIL abort_activity got %0d cycles want 0", we_seen); else pass_cnt++;
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL abort_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask

`ifdef MEM_DMA_FILL_EN
    task automatic test_fill();
        obs_t o;
        int   first;
        int   bad;
        for (int i = 0; i < 3; i++) ref_mem[12'h100 + 12'(i)] = 16'hBEEF;
        fill_mode  = 1'b1;
        fill_value = 16'hBEEF;
        run_xfer(16'h0777, 16'h0100, 16'd3, 10, o);
        fill_mode  = 1'b0;
        total_cnt++; if (o.lat !== 4) $display("FAIL fill_latency got %0d want 4", o.lat); else pass_cnt++;
        total_cnt++; if (o.we_n !== 3) $display("FAIL fill_write_cycles got %0d want 3", o.we_n); else pass_cnt++;
        total_cnt++; if (o.wd !== 16'd3) $display("FAIL fill_words_done got %0d want 3", o.wd); else pass_cnt++;
        bad = mem_diff(first);
        total_cnt++; if (bad !== 0) $display("FAIL fill_memory got %0d bad words (first 0x%0h) want 0", bad, first); else pass_cnt++;
    endtask
`endif

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
`ifdef MEM_DMA_FILL_EN
        fill_mode  = 1'b0;
        fill_value = '0;
`endif
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'($urandom);
        init_req = 1'b1;
        @(negedge clk);
        #1;
        init_req = 1'b0;

        test_reset();
        test_directed_copy();
        test_zero_length();
        test_wrap();
        test_random_copies();
        test_start_while_busy();
        test_reset_abort();
`ifdef MEM_DMA_FILL_EN
        test_fill();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
